cla_sub16_pipe: RTL and testbench

Two-stage pipelined 16-bit subtractor with borrow-in and borrow-out. It computes D = A − B − Bin using 4-bit lookahead groups: the low byte resolves in stage 1 and the high byte in stage 2. A valid/ready handshake on both sides lets it sit in the datapath next to the combinational 16-bit lookahead adder, with full throughput and no operand loss under backpressure.

---
 rtl/cla_sub16_pipe.sv | 173 +++++++++++++++++
 tb/tb_cla_sub16_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_sub16_pipe.sv
// Two-stage pipelined 16-bit subtractor D = A - B - Bin built from 4-bit lookahead groups.
// Optional V/Z flags are enabled by defining CLA_SUB_FLAGS_EN.
module cla_sub16_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] D,
  output logic        Bout,
  output logic        V,
  output logic        Z
);

  typedef struct packed {
    logic [3:0] sum;
    logic       gp;
    logic       gg;
  } grp4_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
  } byte_t;

  // One 4-bit lookahead group; bn is the already-inverted subtrahend nibble.
  function automatic grp4_t cla4(input logic [3:0] a, input logic [3:0] bn, input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    grp4_t      r;
    p    = a ^ bn;
    g    = a & bn;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    r.sum = p ^ c;
    r.gp  = &p;
    r.gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

  // Two groups combined through their group propagate/generate terms.
  function automatic byte_t cla8(input logic [7:0] a, input logic [7:0] bn, input logic cin);
    grp4_t lo;
    grp4_t hi;
    logic  c4;
    byte_t r;
    lo     = cla4(a[3:0], bn[3:0], cin);
    c4     = lo.gg | (lo.gp & cin);
    hi     = cla4(a[7:4], bn[7:4], c4);
    r.sum  = {hi.sum, lo.sum};
    r.cout = hi.gg | (hi.gp & lo.gg) | (hi.gp & lo.gp & cin);
    return r;
  endfunction

  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_d_lo_q, s1_d_lo_d;
  logic       s1_borrow_q, s1_borrow_d;
  logic [7:0] s1_a_hi_q, s1_a_hi_d;
  logic [7:0] s1_b_hi_q, s1_b_hi_d;

  logic        s2_valid_q, s2_valid_d;
  logic [15:0] s2_d_q, s2_d_d;
  logic        s2_bout_q, s2_bout_d;

  logic  s2_load;
  logic  s1_load;
  logic  accept;
  byte_t lo_res;
  byte_t hi_res;

  assign s2_load  = ~s2_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  // Gated by rst_n so nothing is offered while reset is held.
  assign in_ready = rst_n & s1_load;
  assign accept   = in_valid & in_ready;

  always_comb begin
    lo_res      = cla8(A[7:0], ~B[7:0], ~Bin);
    s1_valid_d  = s1_valid_q;
    s1_d_lo_d   = s1_d_lo_q;
    s1_borrow_d = s1_borrow_q;
    s1_a_hi_d   = s1_a_hi_q;
    s1_b_hi_d   = s1_b_hi_q;
    if (s1_load) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_d_lo_d   = lo_res.sum;
      s1_borrow_d = ~lo_res.cout;
      s1_a_hi_d   = A[15:8];
      s1_b_hi_d   = B[15:8];
    end
  end

  always_comb begin
    hi_res     = cla8(s1_a_hi_q, ~s1_b_hi_q, ~s1_borrow_q);
    s2_valid_d = s2_valid_q;
    s2_d_d     = s2_d_q;
    s2_bout_d  = s2_bout_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d_d    = {hi_res.sum, s1_d_lo_q};
        s2_bout_d = ~hi_res.cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_d_lo_q   <= 8'h00;
      s1_borrow_q <= 1'b0;
      s1_a_hi_q   <= 8'h00;
      s1_b_hi_q   <= 8'h00;
      s2_valid_q  <= 1'b0;
      s2_d_q      <= 16'h0000;
      s2_bout_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_d_lo_q   <= s1_d_lo_d;
      s1_borrow_q <= s1_borrow_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s1_b_hi_q   <= s1_b_hi_d;
      s2_valid_q  <= s2_valid_d;
      s2_d_q      <= s2_d_d;
      s2_bout_q   <= s2_bout_d;
    end
  end

`ifdef CLA_SUB_FLAGS_EN
  logic s2_v_q, s2_v_d;
  logic s2_z_q, s2_z_d;

  // Sign bits of A/B come from the stage-1 high operand registers.
  always_comb begin
    s2_v_d = s2_v_q;
    s2_z_d = s2_z_q;
    if (s2_load && s1_valid_q) begin
      s2_v_d = (s1_a_hi_q[7] ^ s1_b_hi_q[7]) & (hi_res.sum[7] ^ s1_a_hi_q[7]);
      s2_z_d = ~(|{hi_res.sum, s1_d_lo_q});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      s2_z_q <= 1'b0;
    end else begin
      s2_v_q <= s2_v_d;
      s2_z_q <= s2_z_d;
    end
  end

  assign V = s2_v_q;
  assign Z = s2_z_q;
`else
  assign V = 1'b0;
  assign Z = 1'b0;
`endif

  assign out_valid = s2_valid_q;
  assign D         = s2_d_q;
  assign Bout      = s2_bout_q;

endmodule

// File: tb/tb_cla_sub16_pipe.sv
// Bench for cla_sub16_pipe: directed vector table, backpressure and reset sequences,
// plus randomized traffic checked by an arithmetic scoreboard.
module tb_cla_sub16_pipe;

`ifdef CLA_SUB_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] A = 16'h0;
  logic [15:0] B = 16'h0;
  logic        Bin = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] D;
  logic        Bout;
  logic        V;
  logic        Z;

  cla_sub16_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D),
    .Bout     (Bout),
    .V        (V),
    .Z        (Z)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int emitted = 0;

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        v;
    logic        z;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        v;
    logic        z;
  } vec_t;

  res_t exp_q[$];

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] full;
    res_t        r;
    full   = {1'b0, a} - {1'b0, b} - {16'h0, bin};
    r.d    = full[15:0];
    r.bout = full[16];
    r.v    = FlagsEn & (a[15] ^ b[15]) & (r.d[15] ^ a[15]);
    r.z    = FlagsEn & (r.d == 16'h0);
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: sampled mid-cycle where inputs and handshakes are stable.
  logic        stalled = 1'b0;
  logic [15:0] prev_d;
  logic        prev_bout, prev_v, prev_z;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 16'(out_valid), 16'd1);
        check("stall_d", D, prev_d);
        check("stall_flags", 16'({Bout, V, Z}), 16'({prev_bout, prev_v, prev_z}));
      end
      if (out_valid && out_ready) begin
        emitted++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_emit", 16'd1, 16'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("sb_d", D, e.d);
          check("sb_bout", 16'(Bout), 16'(e.bout));
          check("sb_v", 16'(V), 16'(e.v));
          check("sb_z", 16'(Z), 16'(e.z));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, Bin));
      stalled   = out_valid && !out_ready;
      prev_d    = D;
      prev_bout = Bout;
      prev_v    = V;
      prev_z    = Z;
    end
  end

  // Single transfer on an idle pipe, checking the exact two-cycle latency.
  task automatic apply_vec(input vec_t v);
    @(posedge clk); #2;
    A = v.a; B = v.b; Bin = v.bin; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("vec_in_ready", 16'(in_ready), 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("vec_lat1_valid", 16'(out_valid), 16'd0);
    @(posedge clk); #1;
    check("vec_lat2_valid", 16'(out_valid), 16'd1);
    check("vec_d", D, v.d);
    check("vec_bout", 16'(Bout), 16'(v.bout));
    check("vec_v", 16'(V), 16'(v.v & FlagsEn));
    check("vec_z", 16'(Z), 16'(v.z & FlagsEn));
  endtask

  // Presents one operand set and holds it until accepted; called at posedge+2.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int n;
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #3;
      n++;
    end
    if (n >= 50) check("send_timeout", 16'd1, 16'd0);
    @(posedge clk); #2;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{a: 16'h1234, b: 16'h0234, bin: 1'b0, d: 16'h1000, bout: 1'b0, v: 1'b0, z: 1'b0};
    vecs[1] = '{a: 16'h0000, b: 16'h0001, bin: 1'b0, d: 16'hFFFF, bout: 1'b1, v: 1'b0, z: 1'b0};
    vecs[2] = '{a: 16'h0100, b: 16'h0001, bin: 1'b0, d: 16'h00FF, bout: 1'b0, v: 1'b0, z: 1'b0};
    vecs[3] = '{a: 16'h0005, b: 16'h0005, bin: 1'b1, d: 16'hFFFF, bout: 1'b1, v: 1'b0, z: 1'b0};
    vecs[4] = '{a: 16'h0005, b: 16'h0005, bin: 1'b0, d: 16'h0000, bout: 1'b0, v: 1'b0, z: 1'b1};
    vecs[5] = '{a: 16'h8000, b: 16'h0001, bin: 1'b0, d: 16'h7FFF, bout: 1'b0, v: 1'b1, z: 1'b0};
    vecs[6] = '{a: 16'h7FFF, b: 16'hFFFF, bin: 1'b0, d: 16'h8000, bout: 1'b1, v: 1'b1, z: 1'b0};
    vecs[7] = '{a: 16'hFFFF, b: 16'hFFFF, bin: 1'b1, d: 16'hFFFF, bout: 1'b1, v: 1'b0, z: 1'b0};

    // Reset state
    #1;
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_d", D, 16'h0000);
    check("rst_flags", 16'({Bout, V, Z}), 16'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("post_rst_in_ready", 16'(in_ready), 16'd1);

    for (int i = 0; i < 8; i++) begin
      apply_vec(vecs[i]);
      @(posedge clk);
    end

    // Backpressure: five sets with out_ready held low for four cycles.
    begin
      int base;
      @(posedge clk); #2;
      base = emitted;
      out_ready = 1'b0;
      fork
        begin
          for (int i = 0; i < 5; i++) begin
            send(16'h1111 * 16'(i + 3), 16'h0101 * 16'(i), 1'(i));
          end
          in_valid = 1'b0;
        end
        begin
          repeat (2) @(posedge clk);
          #3 check("bp_in_ready_full", 16'(in_ready), 16'd0);
          repeat (2) @(posedge clk);
          #1 out_ready = 1'b1;
        end
      join
      repeat (6) @(posedge clk);
      #1;
      check("bp_drain_empty", 16'(exp_q.size()), 16'd0);
      check("bp_emit_count", 16'(emitted - base), 16'd5);
    end

    // Reset with two sets in flight.
    @(posedge clk); #2;
    out_ready = 1'b0;
    send(16'h4321, 16'h1234, 1'b0);
    send(16'hABCD, 16'h0BCD, 1'b1);
    in_valid = 1'b0;
    #1 check("mid_full_valid", 16'(out_valid), 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    check("mid_rst_d", D, 16'h0000);
    check("mid_rst_flags", 16'({Bout, V, Z}), 16'd0);
    check("mid_rst_in_ready", 16'(in_ready), 16'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_no_emit", 16'(out_valid), 16'd0);
    end
    apply_vec(vecs[5]);
    @(posedge clk);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      A = 16'($urandom);
      B = 16'($urandom);
      Bin = 1'($urandom);
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("rand_drain_empty", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
